dffe_sweep_gen: RTL and testbench
=================================

Name: dffe_sweep_gen

Overview:
- Upstream stimulus stage for the enabled D flip-flop block (ports CLK, D, EN, Q).
- Generates a self-timed D/EN pattern in three parts: a settle interval, a full D sweep with EN low, then the same sweep with EN high.
- Its D and EN outputs drive the flip-flop's D and EN inputs directly, so the flip-flop can be exercised in RTL without a behavioural testbench process.

Parameters:
- W, 2: data width of D; the sweep covers 0 .. 2^W-1.
- HOLD, 5: clock cycles each D value is held; legal range ≥1.
- LEAD, 5: clock cycles of the settle phase (EN=0, D=0); legal range ≥1.

Ports:
- CLK  in  1  Single clock; all state updates on the rising edge.
- RST_N  in  1  Reset, synchronous, active-low.
- START  in  1  Begin a run; sampled only in IDLE.
- PAUSE  in  1  Freeze the run while high; ignored in IDLE.
- D  out  W  Data to the flip-flop; registered.
- EN  out  1  Enable to the flip-flop; registered.
- BUSY  out  1  High in every state except IDLE.
- DONE  out  1  One-cycle pulse after the final sweep step.
- PHASE  out  2  Current state: 0=IDLE, 1=SETUP, 2=SWEEP_OFF, 3=SWEEP_ON.

Behaviour:
- Reset: RST_N low at a rising edge sets state=IDLE, D=0, EN=0, DONE=0, BUSY=0, and clears both counters. Reset overrides all other inputs, including mid-run.
- All outputs are registered; no combinational path from any input to any output.
- Counters:
  - hold_cnt counts 0..HOLD-1 in the sweep states and 0..LEAD-1 in SETUP.
  - step_cnt is W bits and wraps naturally at 2^W-1.
- IDLE:
  - D keeps its last value; EN=0.
  - START=1 at an edge -> next cycle: SETUP, BUSY=1, D=0, EN=0, hold_cnt=0.
- SETUP:
  - Lasts LEAD cycles.
  - On the edge where hold_cnt==LEAD-1 -> SWEEP_OFF, step_cnt=0, hold_cnt=0.
- SWEEP_OFF:
  - EN=0; D=step_cnt.
  - hold_cnt increments each cycle. At HOLD-1 it resets to 0 and step_cnt increments.
  - When step_cnt==2^W-1 and hold_cnt==HOLD-1 -> SWEEP_ON, step_cnt=0, D=0, EN=1.
- SWEEP_ON:
  - EN=1; D=step_cnt; counting is identical to SWEEP_OFF.
  - After the last step completes -> IDLE. On that edge EN=0, D stays at 2^W-1, DONE=1 for exactly one cycle.
- Run length: total BUSY cycles = LEAD + 2·2^W·HOLD. With the defaults this is 5+20+20 = 45.
- PAUSE=1 in a non-IDLE state:
  - State, counters, D and EN hold.
  - BUSY stays 1; DONE stays 0.
  - Resuming continues exactly where the run stopped; no step is lengthened or skipped.
- START while BUSY is ignored; it is not queued.
- START high in the cycle DONE=1 (state is IDLE) is accepted; the next run begins the following cycle.
- PAUSE together with START in IDLE: START wins; PAUSE then takes effect from SETUP onward.
- PHASE reflects the registered state, changing on the same edge as the state.
- D changes only on step boundaries or phase entry; EN changes only on entry to SWEEP_ON or return to IDLE.

Test Plan:
1. Reset release: RST_N=0 for 3 cycles, then 1, START=0 -> D=00, EN=0, BUSY=0, DONE=0, PHASE=0; remains so for 10 cycles.
2. Full run with defaults: one-cycle START pulse ->
   - BUSY high for exactly 45 cycles; PHASE sequence 1(×5), 2(×20), 3(×20).
   - D sequence 00,01,10,11 each 5 cycles in each sweep; EN=0 through SETUP/SWEEP_OFF and 1 through SWEEP_ON.
   - DONE=1 for one cycle with D=11 and EN=0.
3. Pause: assert PAUSE for 7 cycles while in SWEEP_OFF with D=01 and hold_cnt=2 -> D, EN and PHASE frozen for 7 cycles; run completes with BUSY totalling 52 cycles; every D step still 5 cycles long.
4. Ignored and back-to-back START:
   - START pulses mid-SWEEP_ON -> no effect on sequence or length.
   - START held through the DONE cycle -> new SETUP begins on the next cycle with D=00, EN=0.
5. Reset mid-run: RST_N=0 for one edge while in SWEEP_ON with D=10 -> next cycle IDLE, D=00, EN=0, BUSY=0, DONE=0; a fresh START then yields a full 45-cycle run.
6. Integration with the flip-flop: connect D/EN to the flip-flop and run -> flip-flop Q holds its reset/initial value throughout SWEEP_OFF, then follows D one clock later through SWEEP_ON, ending at Q=11.

Source files
------------

// File: rtl/dffe_sweep_gen.sv
// Self-timed D/EN stimulus source for an enabled D flip-flop.
// The run is a settle interval, then a D sweep with EN low, then the same sweep with EN high.
module dffe_sweep_gen #(
  parameter int W    = 2,
  parameter int HOLD = 5,
  parameter int LEAD = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         pause,
  output logic [W-1:0] d,
  output logic         en,
  output logic         busy,
  output logic         done,
  output logic [1:0]   phase
);

  // state     | meaning
  // IDLE      | waiting for start, EN low, D holds last value
  // SETUP     | settle for LEAD cycles with D=0, EN=0
  // SWEEP_OFF | D steps 0..2^W-1, HOLD cycles each, EN=0
  // SWEEP_ON  | same sweep with EN=1, then DONE pulse and back to IDLE
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SETUP     = 2'd1,
    SWEEP_OFF = 2'd2,
    SWEEP_ON  = 2'd3
  } state_t;

  localparam int CMAX = (LEAD > HOLD) ? LEAD : HOLD;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] LEAD_LAST = CW'(LEAD - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);
  localparam logic [W-1:0]  STEP_LAST = {W{1'b1}};

  state_t        state, state_n;
  logic [CW-1:0] hold_cnt, hold_n;
  logic [W-1:0]  step_cnt, step_n;
  logic [W-1:0]  d_n;
  logic          en_n, done_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
      step_cnt <= '0;
      d        <= '0;
      en       <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      hold_cnt <= hold_n;
      step_cnt <= step_n;
      d        <= d_n;
      en       <= en_n;
      done     <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    hold_n  = hold_cnt;
    step_n  = step_cnt;
    d_n     = d;
    en_n    = en;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        en_n = 1'b0;
        if (start) begin
          state_n = SETUP;
          hold_n  = '0;
          d_n     = '0;
        end
      end
      SETUP: begin
        if (!pause) begin
          if (hold_cnt == LEAD_LAST) begin
            state_n = SWEEP_OFF;
            hold_n  = '0;
            step_n  = '0;
            d_n     = '0;
          end else begin
            hold_n = hold_cnt + 1'b1;
          end
        end
      end
      SWEEP_OFF, SWEEP_ON: begin
        if (!pause) begin
          if (hold_cnt != HOLD_LAST) begin
            hold_n = hold_cnt + 1'b1;
          end else begin
            hold_n = '0;
            step_n = step_cnt + 1'b1;
            d_n    = step_cnt + 1'b1;
            if (step_cnt == STEP_LAST) begin
              // step_cnt wraps to 0 on its own; the last ON step keeps D at full scale
              if (state == SWEEP_OFF) begin
                state_n = SWEEP_ON;
                en_n    = 1'b1;
              end else begin
                state_n = IDLE;
                en_n    = 1'b0;
                d_n     = d;
                done_n  = 1'b1;
              end
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy  = (state != IDLE);
  assign phase = state;

endmodule

// File: tb/tb_dffe_sweep_gen.sv
// Scoreboard bench for dffe_sweep_gen: expected per-cycle outputs are queued
// when a run is launched and compared every cycle on the falling edge.
module tb_dffe_sweep_gen;
  localparam int W    = 2;
  localparam int HOLD = 5;
  localparam int LEAD = 5;
  localparam int RUN  = LEAD + 2 * (2 ** W) * HOLD;

  logic         clk = 1'b0;
  logic         rst_n, start, pause;
  logic [W-1:0] d;
  logic         en, busy, done;
  logic [1:0]   phase;
  logic [W-1:0] ff_q;

  typedef struct packed {
    logic [1:0]   phase;
    logic [W-1:0] d;
    logic         en;
    logic         busy;
    logic         done;
  } rec_t;

  rec_t sb[$];
  bit   start_hook[int];
  bit   pause_hook[int];
  int   rst_idx;
  int   n_checks = 0;
  int   n_errors = 0;
  int   busy_cnt;
  bit   chk_q = 1'b0;
  logic [W-1:0] exp_ff;

  dffe_sweep_gen #(.W(W), .HOLD(HOLD), .LEAD(LEAD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause),
    .d(d), .en(en), .busy(busy), .done(done), .phase(phase)
  );

  // downstream enabled flip-flop, reset alongside the generator
  always_ff @(posedge clk) begin
    if (!rst_n)  ff_q <= '0;
    else if (en) ff_q <= d;
  end

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic rec_t mk(input logic [1:0] p, input int dv, input logic e,
                              input logic b, input logic dn);
    rec_t r;
    r.phase = p;
    r.d     = W'(dv);
    r.en    = e;
    r.busy  = b;
    r.done  = dn;
    return r;
  endfunction

  // one full run as seen from the cycle after START is taken, ending with the DONE cycle
  task automatic push_run(input int pause_at, input int pause_len);
    rec_t base[$];
    for (int i = 0; i < LEAD; i++) base.push_back(mk(2'd1, 0, 1'b0, 1'b1, 1'b0));
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < 2 ** W; s++)
        for (int h = 0; h < HOLD; h++)
          base.push_back(mk((p == 1) ? 2'd3 : 2'd2, s, p == 1, 1'b1, 1'b0));
    foreach (base[i]) begin
      sb.push_back(base[i]);
      if (i == pause_at) repeat (pause_len) sb.push_back(base[i]);
    end
    sb.push_back(mk(2'd0, 2 ** W - 1, 1'b0, 1'b0, 1'b1));
  endtask

  task automatic clear_hooks();
    start_hook.delete();
    pause_hook.delete();
    rst_idx  = -1;
    busy_cnt = 0;
  endtask

  task automatic drain(input string name);
    rec_t e;
    logic [$bits(rec_t)-1:0] ov, ev;
    int j = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      e  = sb.pop_front();
      ov = {phase, d, en, busy, done};
      ev = e;
      check($sformatf("%s_cyc%0d", name, j), 32'(ov), 32'(ev));
      if (busy) busy_cnt++;
      if (chk_q) begin
        check($sformatf("%s_ffq%0d", name, j), 32'(ff_q), 32'(exp_ff));
        if (e.en) exp_ff = e.d;
      end
      if (start_hook.exists(j)) start = start_hook[j];
      if (pause_hook.exists(j)) pause = pause_hook[j];
      if (j == rst_idx + 1 && rst_idx >= 0) rst_n = 1'b1;
      if (j == rst_idx) begin
        rst_n = 1'b0;
        sb.delete();
        sb.push_back(mk(2'd0, 0, 1'b0, 1'b0, 1'b0));
      end
      j++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    clear_hooks();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // reset release: idle and quiet for 10 cycles
    repeat (10) sb.push_back(mk(2'd0, 0, 1'b0, 1'b0, 1'b0));
    drain("reset");

    // full default run
    clear_hooks();
    start = 1'b1;
    start_hook[0] = 1'b0;
    push_run(-1, 0);
    sb.push_back(mk(2'd0, 2 ** W - 1, 1'b0, 1'b0, 1'b0));
    drain("run");
    check("run_busy_len", 32'(busy_cnt), 32'(RUN));

    // pause 7 cycles in SWEEP_OFF at D=01, hold_cnt=2
    clear_hooks();
    start = 1'b1;
    start_hook[0] = 1'b0;
    pause_hook[LEAD + HOLD + 2] = 1'b1;
    pause_hook[LEAD + HOLD + 2 + 7] = 1'b0;
    push_run(LEAD + HOLD + 2, 7);
    sb.push_back(mk(2'd0, 2 ** W - 1, 1'b0, 1'b0, 1'b0));
    drain("pause");
    check("pause_busy_len", 32'(busy_cnt), 32'(RUN + 7));

    // ignored START mid-SWEEP_ON, then START held through DONE starts a second run
    clear_hooks();
    start = 1'b1;
    start_hook[0] = 1'b0;
    start_hook[30] = 1'b1;
    start_hook[31] = 1'b0;
    start_hook[RUN - 1] = 1'b1;
    start_hook[RUN + 1] = 1'b0;
    push_run(-1, 0);
    push_run(-1, 0);
    sb.push_back(mk(2'd0, 2 ** W - 1, 1'b0, 1'b0, 1'b0));
    drain("b2b");
    check("b2b_busy_len", 32'(busy_cnt), 32'(2 * RUN));

    // reset mid SWEEP_ON at D=10, then a fresh full run
    clear_hooks();
    start = 1'b1;
    start_hook[0] = 1'b0;
    rst_idx = LEAD + (2 ** W) * HOLD + 2 * HOLD + 1;
    push_run(-1, 0);
    drain("midrst");
    clear_hooks();
    start = 1'b1;
    start_hook[0] = 1'b0;
    push_run(-1, 0);
    sb.push_back(mk(2'd0, 2 ** W - 1, 1'b0, 1'b0, 1'b0));
    drain("fresh");
    check("fresh_busy_len", 32'(busy_cnt), 32'(RUN));

    // downstream flip-flop tracks D one clock later only while EN is high
    clear_hooks();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_ff = '0;
    chk_q = 1'b1;
    start = 1'b1;
    start_hook[0] = 1'b0;
    push_run(-1, 0);
    sb.push_back(mk(2'd0, 2 ** W - 1, 1'b0, 1'b0, 1'b0));
    drain("ffint");
    chk_q = 1'b0;
    check("ff_final", 32'(ff_q), 32'(2 ** W - 1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
